norm_arbiter: RTL and testbench
===============================

NORM_ARBITER -- requirements
Module: norm_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, 16, data width; NREQ, 4, requester count (2..8); DEPTH, 8, max in-flight operations (power of 2).
REQ-002 Ports SHALL be, clock and reset first:
  clock  in  1  single clock, rising edge.
  reset_n  in  1  asynchronous, active-low reset.
  req_valid_i  in  NREQ  per-requester operand valid.
  req_ready_o  out  NREQ  per-requester grant, one-hot or zero.
  req_data_i  in  NREQ*WIDTH  operands; requester k at bits [k*WIDTH +: WIDTH].
  nu_valid_o  out  1  issue strobe to shared normalize unit.
  nu_data_o  out  WIDTH  operand to normalize unit.
  nu_valid_i  in  1  normalize unit result valid.
  nu_data_i  in  WIDTH  normalize unit shifted result.
  nu_norm_i  in  $clog2(WIDTH)  normalize unit shift count.
  res_valid_o  out  NREQ  one-hot result strobe to the owning requester.
  res_data_o  out  WIDTH  result data, shared bus.
  res_norm_o  out  $clog2(WIDTH)  result shift count, shared bus.
  inflight_o  out  $clog2(DEPTH+1)  operations issued but not yet returned.
  err_o  out  1  sticky: result arrived with no outstanding tag.

Function
REQ-003 Block SHALL share one pipelined normalize unit (fixed, unknown latency; in-order; no backpressure) among NREQ requesters.
REQ-004 Handshake SHALL be: transfer on requester k when req_valid_i[k] and req_ready_o[k] are both high at a rising edge; req_ready_o SHALL be combinational from req_valid_i, rr_ptr and credit only.
REQ-005 Grant SHALL be round-robin: scan from rr_ptr upward modulo NREQ; first requester with req_valid_i high is granted; at most one grant per cycle.
REQ-006 After a grant to k, rr_ptr SHALL become (k+1) mod NREQ; with no grant, rr_ptr SHALL hold.
REQ-007 Credit: grants SHALL be allowed only when inflight_o < DEPTH; a result return in the same cycle SHALL NOT create credit for that cycle.
REQ-008 Issue SHALL be registered: cycle after a transfer, nu_valid_o=1 and nu_data_o=granted operand; otherwise nu_valid_o=0 and nu_data_o holds.
REQ-009 On each transfer the granted index SHALL be pushed into a DEPTH-entry tag FIFO (wrap-around read/write pointers).
REQ-010 On nu_valid_i=1 with FIFO non-empty, the head tag t SHALL be popped; next cycle res_valid_o = one-hot(t), res_data_o = nu_data_i, res_norm_o = nu_norm_i.
REQ-011 With no return, res_valid_o SHALL be 0 and res_data_o/res_norm_o SHALL hold.
REQ-012 On nu_valid_i=1 with FIFO empty, the result SHALL be dropped (res_valid_o stays 0) and err_o SHALL set and remain 1 until reset.
REQ-013 inflight_o SHALL be +1 per transfer, -1 per valid pop, unchanged on simultaneous transfer and pop; never exceeds DEPTH.
REQ-014 End-to-end latency SHALL be 1 + L + 1 cycles from transfer edge to res_valid_o, where L is the normalize-unit latency.
REQ-015 Results SHALL be delivered in issue order; requester ordering is preserved per requester and globally.

Reset
REQ-016 On reset_n low, immediately and independent of clock: req_ready_o=0 (held by credit/ptr logic), nu_valid_o=0, nu_data_o=0, res_valid_o=0, res_data_o=0, res_norm_o=0, inflight_o=0, err_o=0, rr_ptr=0, FIFO empty.
REQ-017 Reset mid-operation SHALL discard all outstanding tags; the normalize unit SHALL be reset by the same reset_n so no stale result returns.
REQ-018 First grant SHALL be possible on the first rising edge after reset_n deasserts.

Verification
REQ-019 Single requester: after reset, req 2 sends 0x0001 -> nu_data_o=0x0001 one cycle later; res_valid_o=4'b0100, res_data_o=0x8000, res_norm_o=15 at 2+L cycles.
REQ-020 All four req_valid_i high for 8 cycles, rr_ptr=0 -> grants 0,1,2,3,0,1,2,3; results return tagged 0,1,2,3,0,1,2,3 in order.
REQ-021 Credit: DEPTH=8, L=20, all requesters valid -> exactly 8 grants, then req_ready_o=0 until first return; inflight_o peaks at 8, never 9.
REQ-022 Simultaneous grant and return at inflight_o=5 -> inflight_o stays 5; at inflight_o=8 with return -> no grant that cycle, inflight_o=7 next.
REQ-023 Spurious nu_valid_i with inflight_o=0 -> res_valid_o stays 0, err_o=1 next cycle and held; cleared only by reset_n.
REQ-024 reset_n pulsed low with 6 in flight -> all outputs 0 asynchronously, inflight_o=0; post-reset traffic with random operands matches reference leading-zero normalization (all-zero operand gives norm WIDTH-1, data 0).

Source files
------------

// File: rtl/norm_arbiter.sv
// Round-robin arbiter that shares one pipelined normalize unit among NREQ requesters
// and returns each in-order result to the requester that issued it, using a tag FIFO.
module norm_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NREQ-1:0]            req_valid_i,
    output logic [NREQ-1:0]            req_ready_o,
    input  logic [NREQ*WIDTH-1:0]      req_data_i,
    output logic                       nu_valid_o,
    output logic [WIDTH-1:0]           nu_data_o,
    input  logic                       nu_valid_i,
    input  logic [WIDTH-1:0]           nu_data_i,
    input  logic [$clog2(WIDTH)-1:0]   nu_norm_i,
    output logic [NREQ-1:0]            res_valid_o,
    output logic [WIDTH-1:0]           res_data_o,
    output logic [$clog2(WIDTH)-1:0]   res_norm_o,
    output logic [$clog2(DEPTH+1)-1:0] inflight_o,
    output logic                       err_o
);

    localparam int NW = $clog2(WIDTH);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic             nu_valid_q, nu_valid_d;
    logic [WIDTH-1:0] nu_data_q, nu_data_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [IW-1:0]    tag_mem_q [DEPTH];
    logic [IW-1:0]    tag_mem_d [DEPTH];
    logic [NREQ-1:0]  res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [NW-1:0]    res_norm_q, res_norm_d;
    logic [CW-1:0]    inflight_q, inflight_d;
    logic             err_q, err_d;

    logic             credit_ok;
    logic             grant_any;
    logic [IW-1:0]    grant_idx;
    logic [NREQ-1:0]  grant_vec;
    logic [IW:0]      scan_sum;
    logic [IW-1:0]    scan_idx;
    logic             transfer;
    logic             pop;
    logic             spurious;

    // Credit is withheld while reset is asserted so no grant is ever shown during reset.
    // A return in the current cycle never frees a slot until the counter updates.
    always_comb begin
        credit_ok = reset_n && (inflight_q < CW'(DEPTH));
        grant_any = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_sum = {1'b0, rr_ptr_q} + (IW+1)'(i);
            if (scan_sum >= (IW+1)'(NREQ)) begin
                scan_sum = scan_sum - (IW+1)'(NREQ);
            end
            scan_idx = scan_sum[IW-1:0];
            if (!grant_any && req_valid_i[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
        if (grant_any && credit_ok) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    assign transfer = grant_any && credit_ok;
    // The tag FIFO occupancy always equals the in-flight count, so it doubles as the empty flag.
    assign pop      = nu_valid_i && (inflight_q != '0);
    assign spurious = nu_valid_i && (inflight_q == '0);

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        nu_valid_d  = transfer;
        nu_data_d   = nu_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        tag_mem_d   = tag_mem_q;
        res_valid_d = '0;
        res_data_d  = res_data_q;
        res_norm_d  = res_norm_q;
        inflight_d  = inflight_q;
        err_d       = err_q | spurious;

        if (transfer) begin
            if (grant_idx == IW'(NREQ-1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + IW'(1);
            end
            nu_data_d           = req_data_i[grant_idx*WIDTH +: WIDTH];
            tag_mem_d[wr_ptr_q] = grant_idx;
            wr_ptr_d            = wr_ptr_q + PW'(1);
        end

        if (pop) begin
            res_valid_d[tag_mem_q[rd_ptr_q]] = 1'b1;
            res_data_d = nu_data_i;
            res_norm_d = nu_norm_i;
            rd_ptr_d   = rd_ptr_q + PW'(1);
        end

        case ({transfer, pop})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q    <= '0;
            nu_valid_q  <= 1'b0;
            nu_data_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            tag_mem_q   <= '{default: '0};
            res_valid_q <= '0;
            res_data_q  <= '0;
            res_norm_q  <= '0;
            inflight_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            nu_valid_q  <= nu_valid_d;
            nu_data_q   <= nu_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            tag_mem_q   <= tag_mem_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_norm_q  <= res_norm_d;
            inflight_q  <= inflight_d;
            err_q       <= err_d;
        end
    end

    assign req_ready_o = grant_vec;
    assign nu_valid_o  = nu_valid_q;
    assign nu_data_o   = nu_data_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_norm_o  = res_norm_q;
    assign inflight_o  = inflight_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_norm_arbiter.sv
// Directed bench for norm_arbiter with a fixed-latency normalize unit model (latency L)
// that shares the arbiter's reset.
module tb_norm_arbiter;

    localparam int WIDTH = 16;
    localparam int NREQ  = 4;
    localparam int DEPTH = 8;
    localparam int L     = 20;

    logic                clock = 1'b0;
    logic                reset_n;
    logic [NREQ-1:0]     req_valid_i;
    logic [NREQ-1:0]     req_ready_o;
    logic [NREQ*WIDTH-1:0] req_data_i;
    logic                nu_valid_o;
    logic [WIDTH-1:0]    nu_data_o;
    logic                nu_valid_i;
    logic [WIDTH-1:0]    nu_data_i;
    logic [3:0]          nu_norm_i;
    logic [NREQ-1:0]     res_valid_o;
    logic [WIDTH-1:0]    res_data_o;
    logic [3:0]          res_norm_o;
    logic [3:0]          inflight_o;
    logic                err_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic spur = 1'b0;

    logic [L-1:0]     pipe_v;
    logic [WIDTH-1:0] pipe_d [L];

    always #5 clock = ~clock;

    norm_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_data_i  (req_data_i),
        .nu_valid_o  (nu_valid_o),
        .nu_data_o   (nu_data_o),
        .nu_valid_i  (nu_valid_i),
        .nu_data_i   (nu_data_i),
        .nu_norm_i   (nu_norm_i),
        .res_valid_o (res_valid_o),
        .res_data_o  (res_data_o),
        .res_norm_o  (res_norm_o),
        .inflight_o  (inflight_o),
        .err_o       (err_o)
    );

    function automatic logic [WIDTH-1:0] nuShift(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] v;
        v = x;
        for (int k = 0; k < WIDTH-1; k++) if (!v[WIDTH-1]) v = v << 1;
        return v;
    endfunction

    function automatic logic [3:0] nuCount(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] v;
        int c;
        v = x;
        c = 0;
        for (int k = 0; k < WIDTH-1; k++) begin
            if (!v[WIDTH-1]) begin
                v = v << 1;
                c++;
            end
        end
        return 4'(c);
    endfunction

    // Reference normalization used for expected values: locate the top set bit directly.
    function automatic logic [19:0] refNormalize(input logic [WIDTH-1:0] x);
        int msb;
        logic [WIDTH-1:0] d;
        msb = -1;
        for (int k = 0; k < WIDTH; k++) if (x[k]) msb = k;
        if (msb < 0) return {4'(WIDTH-1), 16'h0000};
        d = x << (WIDTH-1-msb);
        return {4'(WIDTH-1-msb), d};
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_v <= '0;
            for (int k = 0; k < L; k++) pipe_d[k] <= '0;
        end else begin
            pipe_v    <= {pipe_v[L-2:0], nu_valid_o};
            pipe_d[0] <= nu_data_o;
            for (int k = 1; k < L; k++) pipe_d[k] <= pipe_d[k-1];
        end
    end

    assign nu_valid_i = pipe_v[L-1] | spur;
    assign nu_data_i  = spur ? 16'hDEAD : nuShift(pipe_d[L-1]);
    assign nu_norm_i  = spur ? 4'd9 : nuCount(pipe_d[L-1]);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NREQ*WIDTH-1:0] data);
        req_valid_i = valid;
        req_data_i  = data;
    endtask

    task automatic nextCycle();
        @(negedge clock);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ready"},    32'(req_ready_o), 32'h0);
        checkOutput({tag, "_nu_valid"}, 32'(nu_valid_o),  32'h0);
        checkOutput({tag, "_nu_data"},  32'(nu_data_o),   32'h0);
        checkOutput({tag, "_res_valid"},32'(res_valid_o), 32'h0);
        checkOutput({tag, "_res_data"}, 32'(res_data_o),  32'h0);
        checkOutput({tag, "_res_norm"}, 32'(res_norm_o),  32'h0);
        checkOutput({tag, "_inflight"}, 32'(inflight_o),  32'h0);
        checkOutput({tag, "_err"},      32'(err_o),       32'h0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no completion, expected finish before timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [15:0] rr_op    [8];
        logic [15:0] rr_exp_d [8];
        logic [3:0]  rr_exp_n [8];
        logic [15:0] post_op  [4];
        logic [19:0] ref_val;
        int base;

        rr_op    = '{16'h0003, 16'h00F0, 16'h1234, 16'h8001, 16'h0000, 16'h4000, 16'h0100, 16'h0FFF};
        rr_exp_d = '{16'hC000, 16'hF000, 16'h91A0, 16'h8001, 16'h0000, 16'h8000, 16'h8000, 16'hFFF0};
        rr_exp_n = '{4'd14, 4'd8, 4'd3, 4'd0, 4'd15, 4'd1, 4'd7, 4'd4};

        reset_n = 1'b0;
        applyStimulus('0, '0);
        #3;
        applyStimulus(4'hF, '0);
        #1;
        checkResetState("por");
        applyStimulus('0, '0);
        nextCycle();
        reset_n = 1'b1;

        // single requester 2, operand 0x0001
        applyStimulus(4'b0100, {16'h0000, 16'h0001, 16'h0000, 16'h0000});
        #1 checkOutput("single_ready", 32'(req_ready_o), 32'h4);
        nextCycle();
        applyStimulus('0, '0);
        checkOutput("single_issue_v", 32'(nu_valid_o), 32'h1);
        checkOutput("single_issue_d", 32'(nu_data_o), 32'h0001);
        checkOutput("single_inflight", 32'(inflight_o), 32'h1);
        nextCycle();
        checkOutput("single_issue_drop", 32'(nu_valid_o), 32'h0);
        checkOutput("single_issue_hold", 32'(nu_data_o), 32'h0001);
        waitCycles(19);
        checkOutput("single_early", 32'(res_valid_o), 32'h0);
        nextCycle();
        checkOutput("single_res_v", 32'(res_valid_o), 32'h4);
        checkOutput("single_res_d", 32'(res_data_o), 32'h8000);
        checkOutput("single_res_n", 32'(res_norm_o), 32'd15);
        checkOutput("single_drained", 32'(inflight_o), 32'h0);
        nextCycle();
        checkOutput("single_res_clr", 32'(res_valid_o), 32'h0);
        checkOutput("single_hold_d", 32'(res_data_o), 32'h8000);
        checkOutput("single_hold_n", 32'(res_norm_o), 32'd15);

        // reset pulse brings rr_ptr back to 0
        reset_n = 1'b0;
        #1;
        checkOutput("pulse_res_d", 32'(res_data_o), 32'h0);
        checkOutput("pulse_res_n", 32'(res_norm_o), 32'h0);
        nextCycle();
        reset_n = 1'b1;

        // all four valid for 8 cycles: rotation and in-order tagged returns
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                checkOutput("rr_issue_d", 32'(nu_data_o), 32'(rr_op[i-1]));
                checkOutput("rr_inflight", 32'(inflight_o), 32'(i));
            end
            base = (i / 4) * 4;
            applyStimulus(4'hF, {rr_op[base+3], rr_op[base+2], rr_op[base+1], rr_op[base]});
            #1 checkOutput("rr_grant", 32'(req_ready_o), 32'(1 << (i % 4)));
            nextCycle();
        end
        checkOutput("rr_issue_d", 32'(nu_data_o), 32'(rr_op[7]));
        checkOutput("rr_inflight_peak", 32'(inflight_o), 32'd8);
        applyStimulus('0, '0);
        waitCycles(14);
        for (int j = 0; j < 8; j++) begin
            checkOutput("rr_res_v", 32'(res_valid_o), 32'(1 << (j % 4)));
            checkOutput("rr_res_d", 32'(res_data_o), 32'(rr_exp_d[j]));
            checkOutput("rr_res_n", 32'(res_norm_o), 32'(rr_exp_n[j]));
            checkOutput("rr_drain", 32'(inflight_o), 32'(7 - j));
            nextCycle();
        end
        checkOutput("rr_res_idle", 32'(res_valid_o), 32'h0);
        checkOutput("rr_empty", 32'(inflight_o), 32'h0);

        // credit exhaustion with every requester permanently valid
        applyStimulus(4'hF, {16'h4444, 16'h3333, 16'h2222, 16'h1111});
        for (int i = 0; i < 8; i++) begin
            #1 checkOutput("cr_grant", 32'(req_ready_o), 32'(1 << (i % 4)));
            nextCycle();
        end
        for (int c = 0; c < 13; c++) begin
            checkOutput("cr_stall_ready", 32'(req_ready_o), 32'h0);
            checkOutput("cr_stall_inflight", 32'(inflight_o), 32'd8);
            nextCycle();
        end
        checkOutput("cr_return_seen", 32'(nu_valid_i), 32'h1);
        checkOutput("cr_no_borrow", 32'(req_ready_o), 32'h0);
        checkOutput("cr_full", 32'(inflight_o), 32'd8);
        nextCycle();
        checkOutput("cr_after_pop", 32'(inflight_o), 32'd7);
        checkOutput("cr_regrant", 32'(req_ready_o), 32'h1);
        applyStimulus('0, '0);
        waitCycles(8);
        checkOutput("cr_drained", 32'(inflight_o), 32'h0);

        // simultaneous grant and return at five in flight
        applyStimulus(4'hF, {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0});
        for (int i = 0; i < 5; i++) begin
            #1 checkOutput("sim_grant", 32'(req_ready_o), 32'(1 << (i % 4)));
            nextCycle();
        end
        applyStimulus('0, '0);
        checkOutput("sim_five", 32'(inflight_o), 32'd5);
        waitCycles(16);
        checkOutput("sim_return_seen", 32'(nu_valid_i), 32'h1);
        checkOutput("sim_pre", 32'(inflight_o), 32'd5);
        applyStimulus(4'b0010, {16'h0000, 16'h0000, 16'h0020, 16'h0000});
        #1 checkOutput("sim_ready", 32'(req_ready_o), 32'h2);
        nextCycle();
        checkOutput("sim_hold", 32'(inflight_o), 32'd5);
        checkOutput("sim_issue_v", 32'(nu_valid_o), 32'h1);
        checkOutput("sim_issue_d", 32'(nu_data_o), 32'h0020);
        checkOutput("sim_res_v", 32'(res_valid_o), 32'h1);
        applyStimulus('0, '0);
        nextCycle();
        checkOutput("sim_dec", 32'(inflight_o), 32'd4);
        checkOutput("sim_res_v2", 32'(res_valid_o), 32'h2);
        waitCycles(20);
        checkOutput("sim_last_v", 32'(res_valid_o), 32'h2);
        checkOutput("sim_last_d", 32'(res_data_o), 32'h8000);
        checkOutput("sim_last_n", 32'(res_norm_o), 32'd10);
        checkOutput("sim_empty", 32'(inflight_o), 32'h0);

        // spurious return with nothing outstanding
        checkOutput("spur_err_pre", 32'(err_o), 32'h0);
        spur = 1'b1;
        nextCycle();
        spur = 1'b0;
        checkOutput("spur_res_v", 32'(res_valid_o), 32'h0);
        checkOutput("spur_res_d", 32'(res_data_o), 32'h8000);
        checkOutput("spur_err", 32'(err_o), 32'h1);
        checkOutput("spur_inflight", 32'(inflight_o), 32'h0);
        waitCycles(3);
        checkOutput("spur_err_sticky", 32'(err_o), 32'h1);

        // six in flight, then an asynchronous reset mid-operation
        applyStimulus(4'hF, {$urandom, $urandom});
        for (int i = 0; i < 6; i++) begin
            #1 checkOutput("mid_grant", 32'(req_ready_o), 32'(1 << ((i + 2) % 4)));
            nextCycle();
        end
        applyStimulus('0, '0);
        checkOutput("mid_six", 32'(inflight_o), 32'd6);
        nextCycle();
        #2;
        reset_n = 1'b0;
        applyStimulus(4'hF, '0);
        #1;
        checkResetState("mid");
        nextCycle();
        reset_n = 1'b1;

        // post-reset traffic with random operands, last one zero
        for (int i = 0; i < 4; i++) post_op[i] = (i == 3) ? 16'h0000 : 16'($urandom);
        applyStimulus(4'hF, {post_op[3], post_op[2], post_op[1], post_op[0]});
        for (int i = 0; i < 4; i++) begin
            #1 checkOutput("post_grant", 32'(req_ready_o), 32'(1 << i));
            nextCycle();
        end
        applyStimulus('0, '0);
        checkOutput("post_inflight", 32'(inflight_o), 32'd4);
        waitCycles(18);
        for (int j = 0; j < 4; j++) begin
            ref_val = refNormalize(post_op[j]);
            checkOutput("post_res_v", 32'(res_valid_o), 32'(1 << j));
            checkOutput("post_res_d", 32'(res_data_o), 32'(ref_val[15:0]));
            checkOutput("post_res_n", 32'(res_norm_o), 32'(ref_val[19:16]));
            nextCycle();
        end
        checkOutput("post_idle", 32'(res_valid_o), 32'h0);
        checkOutput("post_empty", 32'(inflight_o), 32'h0);
        checkOutput("post_no_stale_err", 32'(err_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
